cla: RTL and testbench



---
 rtl/cla_pkg.sv | 13 +
 rtl/cla_if.sv | 39 +++
 rtl/cla4.sv | 25 ++
 rtl/cla.sv | 102 ++++++++++
 tb/tb_cla.sv | 121 ++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the carry-lookahead adder.
// CLA_GROUP is the lookahead group width. CLA_DEFAULT_WIDTH is the default operand width.
// cla_groups() returns the number of 4-bit groups for a given operand width.
package cla_pkg;

  localparam int unsigned CLA_GROUP         = 4;
  localparam int unsigned CLA_DEFAULT_WIDTH = 4;

  function automatic int unsigned cla_groups(input int unsigned width);
    return width / CLA_GROUP;
  endfunction

endpackage

// File: rtl/cla_if.sv
// Operand/result bundle for the cla adder.
//   x, y   : WIDTH-bit unsigned addends
//   cin    : carry into bit 0
//   s      : registered WIDTH-bit sum
//   cout   : registered carry out of bit WIDTH-1
//   ovf    : registered signed overflow (present only when CLA_OVF_EN is defined)
// master drives the operands; slave (the adder) drives the result.
interface cla_if
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef CLA_OVF_EN
  logic             ovf;
`endif

  modport master (
    output x, y, cin,
`ifdef CLA_OVF_EN
    input  ovf,
`endif
    input  s, cout
  );

  modport slave (
    input  x, y, cin,
`ifdef CLA_OVF_EN
    output ovf,
`endif
    output s, cout
  );

endinterface

// File: rtl/cla4.sv
// Combinational 4-bit carry-lookahead group.
//   p, g   : per-bit propagate / generate
//   ci     : carry into the group
//   c      : carry into each bit of the group (c[0] == ci)
//   grp_g  : group generate
//   grp_p  : group propagate
// All carries are flat two-level sums of products; no ripple path.
module cla4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       ci,
  output logic [3:0] c,
  output logic       grp_g,
  output logic       grp_p
);

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;

endmodule

// File: rtl/cla.sv
// Carry-lookahead adder with a one-cycle registered result.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset; clears s, cout (and ovf)
//   bus : cla_if.slave carrying x, y, cin in and s, cout (, ovf) out
// {cout, s} = x + y + cin, registered. WIDTH must be a positive multiple of 4.
// Optional feature macro: CLA_OVF_EN adds the registered signed-overflow output ovf.
module cla
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_DEFAULT_WIDTH
) (
  input  logic  clk,
  input  logic  rst,
  cla_if.slave  bus
);

  localparam int unsigned NG = cla_groups(WIDTH);

  if ((WIDTH == 0) || ((WIDTH % CLA_GROUP) != 0)) begin : g_width_check
    $error("cla: WIDTH must be a positive multiple of 4");
  end

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] c;       // carry into each bit
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;   // carry into each group; grp_c[NG] is cout

  assign p = bus.x ^ bus.y;
  assign g = bus.x & bus.y;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla4 u_cla4 (
      .p     (p[k*4 +: 4]),
      .g     (g[k*4 +: 4]),
      .ci    (grp_c[k]),
      .c     (c[k*4 +: 4]),
      .grp_g (grp_g[k]),
      .grp_p (grp_p[k])
    );
  end

  // Second level: each group carry is the flat OR of every upstream generate
  // term (and cin) ANDed with all intervening group propagates.
  logic term;
  logic carry;
  always_comb begin
    grp_c    = '0;
    term     = 1'b0;
    carry    = 1'b0;
    grp_c[0] = bus.cin;
    for (int unsigned k = 1; k <= NG; k++) begin
      term = bus.cin;
      for (int unsigned m = 0; m < k; m++) term = term & grp_p[m];
      carry = term;
      for (int unsigned j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int unsigned m = j + 1; m < k; m++) term = term & grp_p[m];
        carry = carry | term;
      end
      grp_c[k] = carry;
    end
  end

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;

  always_comb begin
    s_d    = p ^ c;
    cout_d = grp_c[NG];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign bus.s    = s_q;
  assign bus.cout = cout_q;

`ifdef CLA_OVF_EN
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = c[WIDTH-1] ^ grp_c[NG];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla.sv
module tb_cla;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  cla_if #(.WIDTH(4))  b4  ();
  cla_if #(.WIDTH(16)) b16 ();

  cla #(.WIDTH(4))  u_cla_w4  (.clk(clk), .rst(rst), .bus(b4));
  cla #(.WIDTH(16)) u_cla_w16 (.clk(clk), .rst(rst), .bus(b16));

  always #5 clk = ~clk;

  // Reference results expected on the outputs right now
  logic [4:0]  exp4   = '0;
  logic [16:0] exp16  = '0;
  logic        expov4 = 1'b0;
  logic        expov16 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_w4"},  32'({b4.cout, b4.s}),   32'(exp4));
    chk({tag, "_w16"}, 32'({b16.cout, b16.s}), 32'(exp16));
`ifdef CLA_OVF_EN
    chk({tag, "_ovf4"},  32'(b4.ovf),  32'(expov4));
    chk({tag, "_ovf16"}, 32'(b16.ovf), 32'(expov16));
`endif
  endtask

  // Apply operands just after an edge, confirm the old result holds until the
  // next edge, then confirm the new result one cycle later.
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci,
                       input logic [15:0] a16, input logic [15:0] b16v, input logic ci16,
                       input string tag);
    int unsigned sum4;
    int unsigned sum16;
    b4.x  = a;   b4.y  = b;    b4.cin  = ci;
    b16.x = a16; b16.y = b16v; b16.cin = ci16;
    #2;
    check_outputs({tag, "_hold"});
    @(posedge clk);
    #1;
    sum4    = int'(a) + int'(b) + int'(ci);
    sum16   = int'(a16) + int'(b16v) + int'(ci16);
    exp4    = sum4[4:0];
    exp16   = sum16[16:0];
    expov4  = (a[3] == b[3]) && (sum4[3] != a[3]);
    expov16 = (a16[15] == b16v[15]) && (sum16[15] != a16[15]);
    check_outputs(tag);
  endtask

  task automatic drive_r(input logic [3:0] a, input logic [3:0] b, input logic ci,
                         input string tag);
    drive(a, b, ci, 16'($urandom), 16'($urandom), 1'($urandom), tag);
  endtask

  initial begin
    b4.x = '0;  b4.y = '0;  b4.cin = 1'b0;
    b16.x = '0; b16.y = '0; b16.cin = 1'b0;

    // Reset takes effect before any clock edge
    #1 rst = 1'b1;
    #1;
    check_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed WIDTH=4 sequence
    drive_r(4'd0, 4'd0, 1'b0, "zero");
    drive_r(4'd1, 4'd0, 1'b0, "one");
    drive_r(4'd2, 4'd2, 1'b1, "two_two_c");
    drive_r(4'd8, 4'd8, 1'b1, "eight_eight_c");

    // Full carry propagation and maximum sum (both widths)
    drive(4'hF, 4'h0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, "full_prop");
    drive(4'hF, 4'hF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "max_sum");
    drive(4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0, "zero_both");

    // Signed overflow cases
    drive(4'h7, 4'h1, 1'b0, 16'h7FFF, 16'h0001, 1'b0, "ovf_pos");
    drive(4'h8, 4'h8, 1'b0, 16'h8000, 16'h8000, 1'b0, "ovf_neg");
    drive(4'h3, 4'h2, 1'b0, 16'h0003, 16'h0002, 1'b0, "no_ovf");

    // Reset mid-operation discards the pending result
    b4.x = 4'h9;  b4.y = 4'h9;  b4.cin = 1'b1;
    b16.x = 16'h1234; b16.y = 16'hF00F; b16.cin = 1'b1;
    #2 rst = 1'b1;
    #1;
    exp4 = '0; exp16 = '0; expov4 = 1'b0; expov16 = 1'b0;
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    rst = 1'b0;
    drive_r(4'h6, 4'h5, 1'b0, "after_rst");

    // Back-to-back exhaustive WIDTH=4, random WIDTH=16 alongside
    for (int unsigned i = 0; i < 16; i++) begin
      for (int unsigned j = 0; j < 16; j++) begin
        for (int unsigned k = 0; k < 2; k++) begin
          drive_r(4'(i), 4'(j), 1'(k), "exh");
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
